// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode types: the {pc, inst} entry carried from fetch to decode.
package inst_fetch_queue_pkg;

   localparam int XLEN          = 32;
   localparam int DEFAULT_DEPTH = 4;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// In-order buffer between fetch and decode; absorbs decode stalls and drops
// everything on a pipeline flush. Full/empty come from the count alone.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [XLEN-1:0]  io_in_pc,
   input  logic [XLEN-1:0]  io_in_inst,
   input  logic             io_in_valid,
   output logic             io_in_ready,
   output logic [XLEN-1:0]  io_out_pc,
   output logic [XLEN-1:0]  io_out_inst,
   output logic             io_out_valid,
   input  logic             io_out_ready,
   input  logic             io_flush,
   output logic [CNT_W-1:0] io_count
);

   localparam int PTR_W = $clog2(DEPTH);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             enq;
   logic             deq;
   fetch_entry_t     head_entry;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      io_in_ready  = 1'b0;
      io_out_valid = 1'b0;
      io_in_ready  = (count != CNT_W'(DEPTH));
      io_out_valid = (count != '0);
   end

   // Handshakes in a flush cycle are visible on the ports but must not move state.
   assign enq = io_in_valid  && io_in_ready  && !io_flush;
   assign deq = io_out_valid && io_out_ready && !io_flush;

   assign head_entry  = mem[head];
   assign io_out_pc   = head_entry.pc;
   assign io_out_inst = head_entry.inst;
   assign io_count    = count;

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (io_flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (deq) head <= head + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is reset so the head read is 0 after reset; flush leaves contents alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (enq) begin
         mem[tail] <= '{pc: io_in_pc, inst: io_in_inst};
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: vector table for fill/drain, hand sequences for the rest.
module tb_inst_fetch_queue;
   import inst_fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clock = 1'b0;
   logic             reset;
   logic [31:0]      io_in_pc, io_in_inst;
   logic             io_in_valid, io_in_ready;
   logic [31:0]      io_out_pc, io_out_inst;
   logic             io_out_valid, io_out_ready;
   logic             io_flush;
   logic [CNT_W-1:0] io_count;

   int checks = 0;
   int errors = 0;

   inst_fetch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .io_in_pc(io_in_pc), .io_in_inst(io_in_inst),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_out_pc(io_out_pc), .io_out_inst(io_out_inst),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_flush(io_flush), .io_count(io_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        in_valid;
      logic [31:0] in_pc;
      logic        out_ready;
      logic        exp_out_valid;
      logic        exp_in_ready;
      int          exp_count;
      logic        chk_pc;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl, input logic rst);
      io_in_valid  = iv;
      io_in_pc     = pc;
      io_in_inst   = inst;
      io_out_ready = ordy;
      io_flush     = fl;
      reset        = rst;
   endtask

   // Inputs change at negedge; outputs are sampled #1 later; then the posedge passes.
   task automatic tick();
      @(negedge clock);
   endtask

   function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic ordy,
                               input logic ov, input logic ir, input int c,
                               input logic cp, input logic [31:0] epc);
      vec_t v;
      v.in_valid = iv; v.in_pc = pc; v.out_ready = ordy;
      v.exp_out_valid = ov; v.exp_in_ready = ir; v.exp_count = c;
      v.chk_pc = cp; v.exp_pc = epc;
      return v;
   endfunction

   initial begin
      logic [31:0] exp_head;
      logic [31:0] next_pc;

      // Fill to full with decode stalled, offer a 5th, then drain in order.
      vecs[0]  = mk(1, 32'h1000, 0, 0, 1, 0, 0, 32'h0);
      vecs[1]  = mk(1, 32'h1004, 0, 1, 1, 1, 1, 32'h1000);
      vecs[2]  = mk(1, 32'h1008, 0, 1, 1, 2, 1, 32'h1000);
      vecs[3]  = mk(1, 32'h100C, 0, 1, 1, 3, 1, 32'h1000);
      vecs[4]  = mk(1, 32'h1010, 0, 1, 0, 4, 1, 32'h1000);
      vecs[5]  = mk(1, 32'h1010, 1, 1, 0, 4, 1, 32'h1000);
      vecs[6]  = mk(1, 32'h1010, 1, 1, 1, 3, 1, 32'h1004);
      vecs[7]  = mk(0, 32'h0,    1, 1, 1, 3, 1, 32'h1008);
      vecs[8]  = mk(0, 32'h0,    1, 1, 1, 2, 1, 32'h100C);
      vecs[9]  = mk(0, 32'h0,    1, 1, 1, 1, 1, 32'h1010);
      vecs[10] = mk(0, 32'h0,    0, 0, 1, 0, 0, 32'h0);

      drive(0, 0, 0, 0, 0, 1);
      tick(); tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("reset_out_valid", {31'b0, io_out_valid}, 32'd0);
      check("reset_in_ready",  {31'b0, io_in_ready},  32'd1);
      check("reset_count",     {29'b0, io_count},     32'd0);
      check("reset_out_pc",    io_out_pc,             32'd0);
      check("reset_out_inst",  io_out_inst,           32'd0);
      tick();

      foreach (vecs[i]) begin
         drive(vecs[i].in_valid, vecs[i].in_pc, inst_of(vecs[i].in_pc), vecs[i].out_ready, 0, 0);
         #1;
         check($sformatf("vec%0d_out_valid", i), {31'b0, io_out_valid}, {31'b0, vecs[i].exp_out_valid});
         check($sformatf("vec%0d_in_ready", i),  {31'b0, io_in_ready},  {31'b0, vecs[i].exp_in_ready});
         check($sformatf("vec%0d_count", i),     {29'b0, io_count},     32'(vecs[i].exp_count));
         if (vecs[i].chk_pc) begin
            check($sformatf("vec%0d_out_pc", i),   io_out_pc,   vecs[i].exp_pc);
            check($sformatf("vec%0d_out_inst", i), io_out_inst, inst_of(vecs[i].exp_pc));
         end
         tick();
      end

      // Steady state at count=2 with simultaneous enq/deq; pointers wrap repeatedly.
      drive(1, 32'h4000, inst_of(32'h4000), 0, 0, 0); tick();
      drive(1, 32'h4004, inst_of(32'h4004), 0, 0, 0); tick();
      exp_head = 32'h4000;
      next_pc  = 32'h4008;
      for (int c = 0; c < 10; c++) begin
         drive(1, next_pc, inst_of(next_pc), 1, 0, 0);
         #1;
         check($sformatf("stream%0d_count", c),  {29'b0, io_count}, 32'd2);
         check($sformatf("stream%0d_out_pc", c), io_out_pc,         exp_head);
         tick();
         exp_head += 32'h4;
         next_pc  += 32'h4;
      end
      drive(0, 0, 0, 1, 0, 0); #1; check("stream_drain0_pc", io_out_pc, exp_head); tick();
      exp_head += 32'h4;
      #1; check("stream_drain1_pc", io_out_pc, exp_head); tick();
      #1; check("stream_empty_valid", {31'b0, io_out_valid}, 32'd0);

      // Flush with a concurrent offer and dequeue: neither may take effect.
      for (int k = 0; k < 3; k++) begin
         drive(1, 32'h5000 + 32'(4 * k), inst_of(32'h5000 + 32'(4 * k)), 0, 0, 0);
         tick();
      end
      drive(1, 32'h5FFC, inst_of(32'h5FFC), 1, 1, 0);
      #1;
      check("flush_cycle_count",   {29'b0, io_count},     32'd3);
      check("flush_cycle_valid",   {31'b0, io_out_valid}, 32'd1);
      check("flush_cycle_ready",   {31'b0, io_in_ready},  32'd1);
      tick();
      drive(1, 32'h2000, inst_of(32'h2000), 0, 0, 0);
      #1;
      check("post_flush_count", {29'b0, io_count},     32'd0);
      check("post_flush_valid", {31'b0, io_out_valid}, 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("after_flush_enq_valid", {31'b0, io_out_valid}, 32'd1);
      check("after_flush_enq_pc",    io_out_pc,             32'h2000);
      check("after_flush_enq_count", {29'b0, io_count},     32'd1);
      drive(0, 0, 0, 1, 0, 0); tick();

      // Head held stable under a decode stall while the tail keeps filling.
      drive(1, 32'h3000, 32'hDEADBEEF, 0, 0, 0); tick();
      for (int c = 0; c < 5; c++) begin
         drive(1, 32'h3004 + 32'(4 * c), inst_of(32'h3004 + 32'(4 * c)), 0, 0, 0);
         #1;
         check($sformatf("stall%0d_pc", c),    io_out_pc,         32'h3000);
         check($sformatf("stall%0d_inst", c),  io_out_inst,       32'hDEADBEEF);
         check($sformatf("stall%0d_count", c), {29'b0, io_count}, 32'(c < 3 ? c + 1 : 4));
         tick();
      end

      // Drain to two entries, then reset mid-operation.
      drive(0, 0, 0, 1, 0, 0); tick(); tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("pre_reset_count", {29'b0, io_count}, 32'd2);
      check("pre_reset_pc",    io_out_pc,         32'h3008);
      drive(1, 32'h6000, inst_of(32'h6000), 1, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("mid_reset_count", {29'b0, io_count},     32'd0);
      check("mid_reset_valid", {31'b0, io_out_valid}, 32'd0);
      check("mid_reset_inst",  io_out_inst,           32'd0);
      check("mid_reset_ready", {31'b0, io_in_ready},  32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Decoupling buffer directly downstream of the instruction-fetch stage. Captures each fetched {pc, inst} pair and presents them in order to the decode stage through a valid/ready handshake. Absorbs decode stalls without dropping fetched words, and discards all buffered entries on a pipeline flush (branch redirect or exception).

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- io_in_pc  in  32  PC of the fetched word, from the fetch stage output
- io_in_inst  in  32  fetched instruction word
- io_in_valid  in  1  fetch stage offers an entry this cycle
- io_in_ready  out  1  queue accepts an entry this cycle
- io_out_pc  out  32  PC of the head entry
- io_out_inst  out  32  instruction of the head entry
- io_out_valid  out  1  head entry is valid
- io_out_ready  in  1  decode consumes the head entry this cycle
- io_flush  in  1  discard all entries
- io_count  out  CNT_W  current occupancy, 0..DEPTH

## Operation
- Storage: DEPTH-entry register array of {pc[31:0], inst[31:0]}, plus head and tail pointers of width log2(DEPTH), plus count.
- Enqueue fires when io_in_valid && io_in_ready. Writes the entry at tail, tail+1 (mod DEPTH).
- Dequeue fires when io_out_valid && io_out_ready. Advances head+1 (mod DEPTH).
- count' = count + enq − deq. Simultaneous enq and deq leave count unchanged.
- io_in_ready = (count != DEPTH). No same-cycle pass-through when full, even if decode dequeues in that cycle.
- io_out_valid = (count != 0). io_out_pc/io_out_inst are a combinational read of entry[head].
- Pointer wrap-around: natural modulo-DEPTH overflow. Full and empty are distinguished by count only, never by pointer equality.
- Flush: if io_flush=1, head, tail and count become 0 at the next edge. Any enq/deq in that cycle is ignored, and io_in_ready and io_out_valid still follow the current count. Storage contents are not cleared.
- Reset: head=tail=count=0 and all storage entries 0. Outputs after reset: io_out_valid=0, io_in_ready=1, io_count=0, io_out_pc=0, io_out_inst=0.
- Priority: reset > flush > enq/deq.
- Outputs are held stable while io_out_valid=1 and io_out_ready=0.

## Timing
- Enqueue-to-output latency is 1 cycle. An entry accepted at edge N is visible on io_out_* with io_out_valid=1 after edge N.
- An entry dequeued at edge N is replaced by the next entry (or io_out_valid=0) after edge N.
- io_in_ready deasserts in the cycle after the DEPTH-th accepted entry. It reasserts in the cycle after the first dequeue from full.
- Flush takes effect in one cycle: after the flush edge, io_out_valid=0 and io_count=0. Enqueue is possible in the very next cycle.
- Reset asserted mid-operation clears the queue identically to flush, and also zeros storage.

## Structure
- Shared package holds: XLEN=32, the fetch-entry struct {pc, inst}, and the default queue DEPTH constant.
- The decode stage consumes the same struct.
- No sub-module. Pointer, count and storage logic sit inline; the block is a single FIFO controller.

## Test plan
- Reset, then idle: io_out_valid=0, io_in_ready=1, io_count=0, io_out_pc=0.
- Enqueue pc 0x1000/0x1004/0x1008/0x100C with io_out_ready=0 → io_count=4 and io_in_ready=0. An extra offered entry 0x1010 is not accepted. Then raise io_out_ready: out order is 0x1000, 0x1004, 0x1008, 0x100C, and 0x1010 is accepted once space frees.
- Continuous enq+deq for 10 cycles with count=2 → count stays 2. Pointers wrap past DEPTH, and PCs come out in strict order with no duplicates or gaps.
- Fill 3 entries, then assert io_flush together with io_in_valid and io_out_ready → next cycle io_count=0 and io_out_valid=0, and neither the offered entry nor a dequeue took effect. A new entry 0x2000 then appears on out 1 cycle after acceptance.
- Hold io_out_ready=0 with head 0x3000/inst 0xDEADBEEF for 5 cycles while other entries enqueue → outputs stay stable.
- Assert reset with 2 entries queued → next cycle io_count=0, io_out_valid=0, io_out_inst=0.
